// File: rtl/memory_pkg.sv
// Shared MEM-stage types: E/M and M/W bundles, hazard controls,
// data-bus request and the access FSM states.
package memory_pkg;

  localparam logic [3:0] STORE_STRB_DEF = 4'b1111;

  typedef struct packed {
    logic [31:0] alu_result;
    logic        zero;
    logic [31:0] write_data;
    logic [4:0]  write_reg;
    logic [31:0] pc_branch;
    logic [31:0] pc_plus_4;
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_write;
    logic        branch;
    logic        jump;
  } e_m_reg_t;

  typedef struct packed {
    logic stallM;
    logic flushM;
  } hazard_data_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic [4:0]  write_reg;
    logic        reg_write;
    logic        mem_to_reg;
    logic [31:0] pc_plus_4;
    logic        exc_misalign;
  } m_w_reg_t;

  typedef enum logic {
    REQ,
    DONE
  } mem_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

endpackage

// File: rtl/memory_dbus_ctrl.sv
// Single-outstanding data-bus access FSM; captures load data when
// the pipeline is stalled past the completing cycle.
import memory_pkg::*;

module dbus_ctrl #(
  parameter logic [3:0] STORE_STRB = STORE_STRB_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        need_mem,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        stall,
  input  logic        dresp_ok,
  input  logic [31:0] dresp_data,
  output dbus_req_t   dreq,
  output logic        mem_busy,
  output logic [31:0] read_data
);

  mem_state_t  state;
  mem_state_t  next_state;
  logic [31:0] rdata_q;

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= REQ;
    else       state <= next_state;
  end

  // hold load data once the access has completed
  always_ff @(posedge clk) begin
    if (reset)
      rdata_q <= '0;
    else if (state == REQ && need_mem && dresp_ok)
      rdata_q <= dresp_data;
  end

  // next state and request drive
  always_comb begin
    next_state  = state;
    dreq        = '0;
    dreq.addr   = addr;
    dreq.data   = wdata;
    dreq.strobe = mem_write ? STORE_STRB : 4'b0000;
    unique case (state)
      REQ: begin
        dreq.valid = need_mem;
        if (need_mem && dresp_ok && stall)
          next_state = DONE;
      end
      DONE: begin
        if (!stall)
          next_state = REQ;
      end
      default: next_state = REQ;
    endcase
  end

  assign mem_busy  = need_mem && (state == REQ) && !dresp_ok;
  assign read_data = (state == DONE) ? rdata_q : dresp_data;

endmodule

// File: rtl/memory.sv
// MEM pipeline stage: E/M register, branch resolve, data access.
// Optional MEM_MISALIGN_CHECK_EN suppresses misaligned accesses.
import memory_pkg::*;

module memory #(
  parameter logic [3:0] STORE_STRB = STORE_STRB_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  e_m_reg_t     e_m_reg,
  input  hazard_data_t hazard_data,
  input  logic         dresp_ok,
  input  logic [31:0]  dresp_data,
  output logic         dreq_valid,
  output logic [31:0]  dreq_addr,
  output logic [3:0]   dreq_strobe,
  output logic [31:0]  dreq_data,
  output m_w_reg_t     m_w_reg,
  output logic         pc_src,
  output logic [31:0]  pc_branch,
  output logic [31:0]  aluout,
  output logic         mem_busy
);

  e_m_reg_t    e_m;
  dbus_req_t   dreq;
  logic        need_mem;
  logic        misalign;
  logic [31:0] read_data;

  // E/M pipeline register; flush only lands when not stalled
  always_ff @(posedge clk) begin
    if (reset)
      e_m <= '0;
    else if (!hazard_data.stallM)
      e_m <= hazard_data.flushM ? '0 : e_m_reg;
  end

  assign need_mem = e_m.mem_to_reg | e_m.mem_write;

`ifdef MEM_MISALIGN_CHECK_EN
  assign misalign = need_mem && (e_m.alu_result[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  dbus_ctrl #(.STORE_STRB(STORE_STRB)) u_dbus (
    .clk        (clk),
    .reset      (reset),
    .need_mem   (need_mem & ~misalign),
    .mem_write  (e_m.mem_write),
    .addr       (e_m.alu_result),
    .wdata      (e_m.write_data),
    .stall      (hazard_data.stallM),
    .dresp_ok   (dresp_ok),
    .dresp_data (dresp_data),
    .dreq       (dreq),
    .mem_busy   (mem_busy),
    .read_data  (read_data)
  );

  assign dreq_valid  = dreq.valid;
  assign dreq_addr   = dreq.addr;
  assign dreq_strobe = dreq.strobe;
  assign dreq_data   = dreq.data;

  assign pc_src    = (e_m.branch & e_m.zero) | e_m.jump;
  assign pc_branch = e_m.pc_branch;
  assign aluout    = e_m.alu_result;

  // M/W bundle assembly
  always_comb begin
    m_w_reg              = '0;
    m_w_reg.alu_result   = e_m.alu_result;
    m_w_reg.read_data    = read_data;
    m_w_reg.write_reg    = e_m.write_reg;
    m_w_reg.reg_write    = e_m.reg_write & ~misalign;
    m_w_reg.mem_to_reg   = e_m.mem_to_reg;
    m_w_reg.pc_plus_4    = e_m.pc_plus_4;
    m_w_reg.exc_misalign = misalign;
  end

endmodule

// File: tb/tb_memory.sv
// Directed bench for the MEM stage with a transaction-level model
// and a per-cycle compare process.
import memory_pkg::*;

module tb_memory;

  logic         clk = 1'b0;
  logic         reset;
  e_m_reg_t     em_in;
  hazard_data_t hz;
  logic         ok;
  logic [31:0]  rdata;
  logic         dreq_valid;
  logic [31:0]  dreq_addr;
  logic [3:0]   dreq_strobe;
  logic [31:0]  dreq_data;
  m_w_reg_t     m_w_reg;
  logic         pc_src;
  logic [31:0]  pc_branch;
  logic [31:0]  aluout;
  logic         mem_busy;

  logic ext_stall;
  logic flush;
  logic started = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  memory dut (
    .clk         (clk),
    .reset       (reset),
    .e_m_reg     (em_in),
    .hazard_data (hz),
    .dresp_ok    (ok),
    .dresp_data  (rdata),
    .dreq_valid  (dreq_valid),
    .dreq_addr   (dreq_addr),
    .dreq_strobe (dreq_strobe),
    .dreq_data   (dreq_data),
    .m_w_reg     (m_w_reg),
    .pc_src      (pc_src),
    .pc_branch   (pc_branch),
    .aluout      (aluout),
    .mem_busy    (mem_busy)
  );

  // model: the instruction in M, and whether its access already happened
  e_m_reg_t    m_em;
  logic        m_acc;
  logic [31:0] m_rd;
  logic        x_need;
  logic        x_mis;
  logic        x_valid;
  logic        x_busy;
  logic [31:0] x_rdata;

  always_comb begin
    x_need = m_em.mem_to_reg | m_em.mem_write;
    x_mis  = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
    x_mis  = x_need && (m_em.alu_result % 4 != 0);
`endif
    x_valid   = x_need && !x_mis && !m_acc;
    x_busy    = x_valid && !ok;
    x_rdata   = m_acc ? m_rd : rdata;
    hz.stallM = x_busy | ext_stall;
    hz.flushM = flush;
  end

  always @(posedge clk) begin
    if (reset) begin
      m_em  <= '0;
      m_acc <= 1'b0;
      m_rd  <= '0;
    end else begin
      if (x_valid && ok) m_rd <= rdata;
      if (hz.stallM) begin
        m_acc <= m_acc | (x_valid && ok);
      end else begin
        m_acc <= 1'b0;
        m_em  <= flush ? '0 : em_in;
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (started) begin
      chk("dreq_valid", {31'd0, dreq_valid}, {31'd0, x_valid});
      chk("mem_busy", {31'd0, mem_busy}, {31'd0, x_busy});
      if (x_valid) begin
        chk("dreq_addr", dreq_addr, m_em.alu_result);
        chk("dreq_data", dreq_data, m_em.write_data);
        chk("dreq_strobe", {28'd0, dreq_strobe},
            m_em.mem_write ? 32'hF : 32'h0);
      end
      chk("read_data", m_w_reg.read_data, x_rdata);
      chk("pc_src", {31'd0, pc_src},
          {31'd0, (m_em.branch && m_em.zero) || m_em.jump});
      chk("pc_branch", pc_branch, m_em.pc_branch);
      chk("aluout", aluout, m_em.alu_result);
      chk("mw_alu", m_w_reg.alu_result, m_em.alu_result);
      chk("mw_wreg", {27'd0, m_w_reg.write_reg}, {27'd0, m_em.write_reg});
      chk("mw_rw", {31'd0, m_w_reg.reg_write},
          {31'd0, m_em.reg_write && !x_mis});
      chk("mw_m2r", {31'd0, m_w_reg.mem_to_reg}, {31'd0, m_em.mem_to_reg});
      chk("mw_pc4", m_w_reg.pc_plus_4, m_em.pc_plus_4);
      chk("mw_exc", {31'd0, m_w_reg.exc_misalign}, {31'd0, x_mis});
    end
  end

  function automatic e_m_reg_t ins(
    input logic [31:0] alu, input logic [31:0] wd,
    input logic [31:0] pcb, input logic [4:0] wr,
    input logic rw, input logic m2r, input logic mw,
    input logic br, input logic jp, input logic z);
    e_m_reg_t t;
    t            = '0;
    t.alu_result = alu;
    t.write_data = wd;
    t.pc_branch  = pcb;
    t.pc_plus_4  = 32'h0000_1004;
    t.write_reg  = wr;
    t.reg_write  = rw;
    t.mem_to_reg = m2r;
    t.mem_write  = mw;
    t.branch     = br;
    t.jump       = jp;
    t.zero       = z;
    return t;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    em_in     = '0;
    ext_stall = 1'b0;
    flush     = 1'b0;
    ok        = 1'b0;
    rdata     = '0;
    cyc();
    started = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    chk("rst_valid", {31'd0, dreq_valid}, 32'd0);
    chk("rst_pcsrc", {31'd0, pc_src}, 32'd0);
    chk("rst_mw", m_w_reg.pc_plus_4, 32'd0);

    // load, completes in first request cycle
    em_in = ins(32'h100, 32'h0, 32'h0, 5'd5, 1, 1, 0, 0, 0, 0);
    cyc();
    em_in = '0;
    ok    = 1'b1;
    rdata = 32'hDEADBEEF;
    #1;
    chk("ld_valid", {31'd0, dreq_valid}, 32'd1);
    chk("ld_strobe", {28'd0, dreq_strobe}, 32'h0);
    chk("ld_busy", {31'd0, mem_busy}, 32'd0);
    chk("ld_addr", dreq_addr, 32'h100);
    chk("ld_rdata", m_w_reg.read_data, 32'hDEADBEEF);
    cyc();
    ok = 1'b0;
    #1;
    chk("ld_gone", {31'd0, dreq_valid}, 32'd0);

    // store with three wait cycles
    em_in = ins(32'h200, 32'h12345678, 32'h0, 5'd0, 0, 0, 1, 0, 0, 0);
    cyc();
    em_in = '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("st_busy", {31'd0, mem_busy}, 32'd1);
      chk("st_addr", dreq_addr, 32'h200);
      chk("st_data", dreq_data, 32'h12345678);
      chk("st_strobe", {28'd0, dreq_strobe}, 32'hF);
      cyc();
    end
    ok = 1'b1;
    #1;
    chk("st_done_busy", {31'd0, mem_busy}, 32'd0);
    chk("st_done_valid", {31'd0, dreq_valid}, 32'd1);
    cyc();
    ok = 1'b0;
    #1;
    chk("st_single", {31'd0, dreq_valid}, 32'd0);

    // load completes while another stage holds the stall
    em_in = ins(32'h300, 32'h0, 32'h0, 5'd7, 1, 1, 0, 0, 0, 0);
    cyc();
    em_in     = '0;
    ok        = 1'b1;
    rdata     = 32'hCAFEF00D;
    ext_stall = 1'b1;
    #1;
    chk("hold_rdata0", m_w_reg.read_data, 32'hCAFEF00D);
    cyc();
    ok    = 1'b0;
    rdata = 32'h11111111;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("hold_valid", {31'd0, dreq_valid}, 32'd0);
      chk("hold_busy", {31'd0, mem_busy}, 32'd0);
      chk("hold_rdata", m_w_reg.read_data, 32'hCAFEF00D);
      if (i == 1) ext_stall = 1'b0;
      cyc();
    end
    #1;
    chk("hold_adv", {31'd0, dreq_valid}, 32'd0);

    // branch / jump resolution
    em_in = ins(32'h0, 32'h0, 32'h400, 5'd0, 0, 0, 0, 1, 0, 1);
    cyc();
    #1;
    chk("beq_t", {31'd0, pc_src}, 32'd1);
    chk("beq_tgt", pc_branch, 32'h400);
    em_in = ins(32'h0, 32'h0, 32'h400, 5'd0, 0, 0, 0, 1, 0, 0);
    cyc();
    #1;
    chk("beq_nt", {31'd0, pc_src}, 32'd0);
    em_in = ins(32'h0, 32'h0, 32'h800, 5'd0, 0, 0, 0, 0, 1, 0);
    cyc();
    #1;
    chk("jmp", {31'd0, pc_src}, 32'd1);
    chk("jmp_tgt", pc_branch, 32'h800);

    // plain ALU op forwards its result
    em_in = ins(32'hABCD0000, 32'h0, 32'h0, 5'd9, 1, 0, 0, 0, 0, 0);
    cyc();
    #1;
    chk("alu_fwd", aluout, 32'hABCD0000);
    chk("alu_rw", {31'd0, m_w_reg.reg_write}, 32'd1);

    // reset during a store wait
    em_in = ins(32'h500, 32'hA5A5A5A5, 32'h0, 5'd0, 0, 0, 1, 0, 0, 0);
    cyc();
    em_in = '0;
    #1;
    chk("rs_busy", {31'd0, mem_busy}, 32'd1);
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    rdata = 32'h5A5A5A5A;
    #1;
    chk("rs_valid", {31'd0, dreq_valid}, 32'd0);
    chk("rs_rw", {31'd0, m_w_reg.reg_write}, 32'd0);
    chk("rs_pc4", m_w_reg.pc_plus_4, 32'd0);
    chk("rs_req", m_w_reg.read_data, 32'h5A5A5A5A);

    // flush with no stall gives a bubble
    em_in = ins(32'h600, 32'h77, 32'h0, 5'd0, 0, 0, 1, 0, 0, 0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    em_in = '0;
    #1;
    chk("fl_valid", {31'd0, dreq_valid}, 32'd0);
    chk("fl_busy", {31'd0, mem_busy}, 32'd0);

`ifdef MEM_MISALIGN_CHECK_EN
    em_in = ins(32'h102, 32'h0, 32'h0, 5'd3, 1, 1, 0, 0, 0, 0);
    cyc();
    em_in = '0;
    #1;
    chk("mis_valid", {31'd0, dreq_valid}, 32'd0);
    chk("mis_exc", {31'd0, m_w_reg.exc_misalign}, 32'd1);
    chk("mis_rw", {31'd0, m_w_reg.reg_write}, 32'd0);
    chk("mis_busy", {31'd0, mem_busy}, 32'd0);
`endif

    cyc();
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/memory.md
Name: memory

Overview:
- MEM stage of the 5-stage MIPS pipeline, directly downstream of execute.
- Owns the E/M pipeline register and resolves branch/jump redirects from the execute results.
- Drives a single-outstanding data-bus request for loads and stores.
- Produces the M/W bundle for writeback and the ALU-result forwarding value for execute; requests a pipeline stall while a data access is pending.

Parameters:
- STORE_STRB, 4'b1111, byte strobe driven for word stores.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- e_m_reg  in  e_m_reg_t  execute results (alu_result, zero, write_data, write_reg, pc_branch, pc_plus_4, reg_write, mem_to_reg, mem_write, branch, jump)
- hazard_data  in  hazard_data_t  uses stallM, flushM
- dresp_ok  in  1  data bus: access completes this cycle
- dresp_data  in  32  data bus: load data, valid with dresp_ok
- dreq_valid  out  1  data bus request
- dreq_addr  out  32  byte address
- dreq_strobe  out  4  byte write strobes; 0 means read
- dreq_data  out  32  store data
- m_w_reg  out  m_w_reg_t  alu_result, read_data, write_reg, reg_write, mem_to_reg, pc_plus_4
- pc_src  out  1  redirect fetch
- pc_branch  out  32  redirect target
- aluout  out  32  forwarding value to execute (execute_forward_data.aluout)
- mem_busy  out  1  stall request to the hazard unit

Behaviour:
- E/M register `e_m`, updated on posedge clk:
  - reset: cleared to all-zero (bubble).
  - else if !stallM and flushM: cleared to all-zero.
  - else if !stallM: loaded from e_m_reg.
  - else: held.
- need_mem = e_m.mem_to_reg | e_m.mem_write.
- Combinational outputs from e_m:
  - pc_src = (e_m.branch & e_m.zero) | e_m.jump
  - pc_branch = e_m.pc_branch
  - aluout = e_m.alu_result
  - m_w_reg control/alu fields pass straight through.
- Access FSM (mem_state_t), states REQ and DONE; reset → REQ.
- REQ state:
  - dreq_valid = need_mem.
  - dreq_addr = e_m.alu_result.
  - dreq_data = e_m.write_data.
  - dreq_strobe = STORE_STRB if mem_write, else 0.
  - Request fields stay stable while dreq_valid is high and dresp_ok is low.
- REQ transitions:
  - dresp_ok & need_mem: capture dresp_data into rdata_q.
  - Go to DONE if stallM is high that cycle; stay in REQ if the register advances the same edge.
- DONE state:
  - dreq_valid = 0; no re-issue.
  - On any edge where e_m is loaded or cleared (!stallM): go to REQ.
- mem_busy = need_mem & (state==REQ) & !dresp_ok. It is low for non-memory instructions and during DONE.
- m_w_reg.read_data = (state==DONE) ? rdata_q : dresp_data.
- Latency: minimum 1 cycle in M when dresp_ok is returned in the first request cycle; otherwise 1 + bus wait cycles.
- Exactly one access per instruction; a stall held by another stage must never cause a duplicate store.
- flushM acts only when !stallM. Because mem_busy forces stallM, an outstanding access always completes before a flush lands.
- Reset mid-access: FSM → REQ, e_m cleared, dreq_valid drops the cycle after reset. The data bus shares this reset.

Optional Feature:
- Macro: MEM_MISALIGN_CHECK_EN.
- Defined:
  - need_mem with e_m.alu_result[1:0] != 0 issues no request; mem_busy = 0.
  - m_w_reg.reg_write is forced to 0.
  - Output m_w_reg.exc_misalign is set to 1.
- Undefined:
  - Address passes to the bus unchanged.
  - exc_misalign is tied 0. The field stays in the struct.

Decomposition:
- pipes package gets: m_w_reg_t (including exc_misalign), mem_state_t enum {REQ, DONE}, dbus_req_t {valid, addr, strobe, data}.
- Sub-module dbus_ctrl contains the FSM, rdata_q, and the dreq/mem_busy/read_data logic.
- Top level keeps the E/M register, branch resolution and m_w_reg assembly.

Test Plan:
- Load, alu_result=0x100, dresp_ok in first cycle with data 0xDEADBEEF → dreq_strobe=0, mem_busy never high, m_w_reg.read_data=0xDEADBEEF, one cycle in M.
- Store, write_data=0x12345678, addr 0x200, dresp_ok after 3 wait cycles → mem_busy high exactly 3 cycles, request stable throughout, strobe=1111, single dreq_valid burst.
- Load completes (dresp_ok) while stallM is held 2 more cycles by another stage → state DONE, dreq_valid=0, read_data holds rdata_q; no second request.
- beq with zero=1, pc_branch=0x400 → pc_src=1, pc_branch=0x400. Same with zero=0 → pc_src=0. Jump → pc_src=1 regardless of zero.
- reset asserted mid-store wait → next cycle dreq_valid=0, m_w_reg.reg_write=0, FSM=REQ. flushM with stallM low → bubble with no request.
- MEM_MISALIGN_CHECK_EN, load to 0x102 → no dreq_valid, exc_misalign=1, reg_write=0, mem_busy=0.
